// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-entry operand stage:
// opcode and shifter-control encodings, the buffered entry layout and decode helpers.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

  typedef struct packed {
    logic [3:0]        op;
    logic [3:0]        rd;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [3:0]        imm;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
  } entry_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Non-shift opcodes report SLL control; the ALU ignores it for them.
  function automatic logic [1:0] shift_ctrl_of(input logic [3:0] op);
    case (op)
      OP_SRL:  return SH_SRL;
      OP_SRA:  return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-side input, forwarding buses and ALU-side output of the operand stage.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface ex_operand_stage_if #(parameter int WIDTH = 16);

  logic             In_valid;
  logic             In_ready;
  logic [3:0]       In_op;
  logic [3:0]       In_rd;
  logic [3:0]       In_rs;
  logic [3:0]       In_rt;
  logic [WIDTH-1:0] In_rs_data;
  logic [WIDTH-1:0] In_rt_data;
  logic [3:0]       In_imm;
  logic             Flush;
  logic             Ex_fwd_valid;
  logic [3:0]       Ex_fwd_reg;
  logic [WIDTH-1:0] Ex_fwd_data;
  logic             Mem_fwd_valid;
  logic [3:0]       Mem_fwd_reg;
  logic [WIDTH-1:0] Mem_fwd_data;
  logic             Out_valid;
  logic             Out_ready;
  logic [3:0]       Out_op;
  logic [3:0]       Out_rd;
  logic [WIDTH-1:0] Out_a;
  logic [WIDTH-1:0] Out_b;
  logic [3:0]       Out_shamt;
  logic [1:0]       Out_shift_ctrl;
  logic             Out_is_shift;

  modport master (
    output In_valid, In_op, In_rd, In_rs, In_rt, In_rs_data, In_rt_data, In_imm, Flush,
    output Ex_fwd_valid, Ex_fwd_reg, Ex_fwd_data, Mem_fwd_valid, Mem_fwd_reg, Mem_fwd_data,
    output Out_ready,
    input  In_ready, Out_valid, Out_op, Out_rd, Out_a, Out_b, Out_shamt, Out_shift_ctrl,
    input  Out_is_shift
  );

  modport slave (
    input  In_valid, In_op, In_rd, In_rs, In_rt, In_rs_data, In_rt_data, In_imm, Flush,
    input  Ex_fwd_valid, Ex_fwd_reg, Ex_fwd_data, Mem_fwd_valid, Mem_fwd_reg, Mem_fwd_data,
    input  Out_ready,
    output In_ready, Out_valid, Out_op, Out_rd, Out_a, Out_b, Out_shamt, Out_shift_ctrl,
    output Out_is_shift
  );

endinterface

// File: rtl/ex_operand_stage_fwd_select.sv
// One operand forward mux: EX result beats MEM result beats the fallback value.
// Register 0 is hard-wired and never takes a forwarded value.
module fwd_select #(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       src_i,
  input  logic [WIDTH-1:0] rf_data_i,
  input  logic             ex_valid_i,
  input  logic [3:0]       ex_reg_i,
  input  logic [WIDTH-1:0] ex_data_i,
  input  logic             mem_valid_i,
  input  logic [3:0]       mem_reg_i,
  input  logic [WIDTH-1:0] mem_data_i,
  output logic [WIDTH-1:0] data_o
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_valid_i  && (ex_reg_i  == src_i) && (src_i != 4'd0);
  assign mem_hit = mem_valid_i && (mem_reg_i == src_i) && (src_i != 4'd0);

  always_comb begin
    data_o = rf_data_i;
    if (ex_hit) begin
      data_o = ex_data_i;
    end else if (mem_hit) begin
      data_o = mem_data_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Two-entry operand buffer in front of the ALU/shifter. Operands are forwarded at capture
// and kept fresh while buffered by snooping the EX/MEM result buses every cycle.
module ex_operand_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  ex_operand_stage_if.slave   bus,
  output logic [1:0]          dbg_count_o
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  entry_t     ent_q [2];
  entry_t     ent_d [2];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;

  logic             push;
  logic             pop;
  logic [1:0]       held;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic [WIDTH-1:0] snp_a [2];
  logic [WIDTH-1:0] snp_b [2];
  entry_t           head;

  assign bus.In_ready  = (count_q != FULL_CNT);
  assign bus.Out_valid = (count_q != 2'd0);
  assign dbg_count_o   = count_q;

  // Flush blocks the push even when In_ready is high.
  assign push = bus.In_valid && bus.In_ready && !bus.Flush;
  assign pop  = bus.Out_valid && bus.Out_ready;

  always_comb begin
    held[0] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'b0));
    held[1] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'b1));
  end

  fwd_select #(.WIDTH(WIDTH)) u_cap_a (
    .src_i(bus.In_rs), .rf_data_i(bus.In_rs_data),
    .ex_valid_i(bus.Ex_fwd_valid), .ex_reg_i(bus.Ex_fwd_reg), .ex_data_i(bus.Ex_fwd_data),
    .mem_valid_i(bus.Mem_fwd_valid), .mem_reg_i(bus.Mem_fwd_reg), .mem_data_i(bus.Mem_fwd_data),
    .data_o(cap_a)
  );

  fwd_select #(.WIDTH(WIDTH)) u_cap_b (
    .src_i(bus.In_rt), .rf_data_i(bus.In_rt_data),
    .ex_valid_i(bus.Ex_fwd_valid), .ex_reg_i(bus.Ex_fwd_reg), .ex_data_i(bus.Ex_fwd_data),
    .mem_valid_i(bus.Mem_fwd_valid), .mem_reg_i(bus.Mem_fwd_reg), .mem_data_i(bus.Mem_fwd_data),
    .data_o(cap_b)
  );

  for (genvar i = 0; i < 2; i++) begin : g_snoop
    fwd_select #(.WIDTH(WIDTH)) u_snp_a (
      .src_i(ent_q[i].rs), .rf_data_i(ent_q[i].a_val),
      .ex_valid_i(bus.Ex_fwd_valid), .ex_reg_i(bus.Ex_fwd_reg), .ex_data_i(bus.Ex_fwd_data),
      .mem_valid_i(bus.Mem_fwd_valid), .mem_reg_i(bus.Mem_fwd_reg), .mem_data_i(bus.Mem_fwd_data),
      .data_o(snp_a[i])
    );

    fwd_select #(.WIDTH(WIDTH)) u_snp_b (
      .src_i(ent_q[i].rt), .rf_data_i(ent_q[i].b_val),
      .ex_valid_i(bus.Ex_fwd_valid), .ex_reg_i(bus.Ex_fwd_reg), .ex_data_i(bus.Ex_fwd_data),
      .mem_valid_i(bus.Mem_fwd_valid), .mem_reg_i(bus.Mem_fwd_reg), .mem_data_i(bus.Mem_fwd_data),
      .data_o(snp_b[i])
    );
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];

    for (int i = 0; i < 2; i++) begin
      if (held[i]) begin
        ent_d[i].a_val = snp_a[i];
        ent_d[i].b_val = snp_b[i];
      end
    end

    if (bus.Flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      // The write slot is never a held entry, so capture cannot collide with snooping.
      if (push) begin
        ent_d[wr_ptr_q] = '{op: bus.In_op, rd: bus.In_rd, rs: bus.In_rs, rt: bus.In_rt,
                            imm: bus.In_imm, a_val: cap_a, b_val: cap_b};
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  assign head = ent_q[rd_ptr_q];

  assign bus.Out_op         = head.op;
  assign bus.Out_rd         = head.rd;
  assign bus.Out_a          = head.a_val;
  assign bus.Out_shamt      = head.imm;
  assign bus.Out_is_shift   = is_shift_op(head.op);
  assign bus.Out_shift_ctrl = shift_ctrl_of(head.op);
  assign bus.Out_b          = is_shift_op(head.op) ? {{(WIDTH-4){1'b0}}, head.imm} : head.b_val;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: hand-computed vectors for capture, shift decode,
// forwarding priority, full/ordering, snooping, flush and asynchronous reset.
module tb_ex_operand_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] dbg_count;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [15:0] exp_q[$];

  ex_operand_stage_if #(.WIDTH(16)) bus ();

  ex_operand_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_count_o(dbg_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.In_valid      = 1'b0;
    bus.Flush         = 1'b0;
    bus.Ex_fwd_valid  = 1'b0;
    bus.Mem_fwd_valid = 1'b0;
  endtask

  task automatic drive_in(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                          input logic [15:0] rs_d, input logic [3:0] rt, input logic [15:0] rt_d,
                          input logic [3:0] imm);
    bus.In_valid   = 1'b1;
    bus.In_op      = op;
    bus.In_rd      = rd;
    bus.In_rs      = rs;
    bus.In_rs_data = rs_d;
    bus.In_rt      = rt;
    bus.In_rt_data = rt_d;
    bus.In_imm     = imm;
  endtask

  task automatic set_ex(input logic [3:0] r, input logic [15:0] d);
    bus.Ex_fwd_valid = 1'b1;
    bus.Ex_fwd_reg   = r;
    bus.Ex_fwd_data  = d;
  endtask

  task automatic set_mem(input logic [3:0] r, input logic [15:0] d);
    bus.Mem_fwd_valid = 1'b1;
    bus.Mem_fwd_reg   = r;
    bus.Mem_fwd_data  = d;
  endtask

  initial begin
    idle_in();
    bus.Out_ready    = 1'b0;
    bus.In_op        = 4'h0;
    bus.In_rd        = 4'h0;
    bus.In_rs        = 4'h0;
    bus.In_rt        = 4'h0;
    bus.In_rs_data   = 16'h0;
    bus.In_rt_data   = 16'h0;
    bus.In_imm       = 4'h0;
    bus.Ex_fwd_reg   = 4'h0;
    bus.Ex_fwd_data  = 16'h0;
    bus.Mem_fwd_reg  = 4'h0;
    bus.Mem_fwd_data = 16'h0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", bus.Out_valid, 1'b0);
    check("rst_in_ready", bus.In_ready, 1'b1);
    check("rst_count", dbg_count, 2'd0);
    check("rst_out_a", bus.Out_a, 16'h0);
    check("rst_out_b", bus.Out_b, 16'h0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // Plain ADD, one-cycle latency, then drained
    bus.Out_ready = 1'b1;
    drive_in(4'h0, 4'h1, 4'h3, 16'h1111, 4'h4, 16'h2222, 4'h0);
    tick();
    idle_in();
    check("add_valid", bus.Out_valid, 1'b1);
    check("add_a", bus.Out_a, 16'h1111);
    check("add_b", bus.Out_b, 16'h2222);
    check("add_rd", bus.Out_rd, 4'h1);
    check("add_is_shift", bus.Out_is_shift, 1'b0);
    check("add_ctrl", bus.Out_shift_ctrl, 2'b00);
    tick();
    check("add_drained", bus.Out_valid, 1'b0);

    // Shift decode
    drive_in(OP_SRA, 4'h2, 4'h2, 16'h8000, 4'h9, 16'h9999, 4'h4);
    tick();
    idle_in();
    check("sra_a", bus.Out_a, 16'h8000);
    check("sra_b", bus.Out_b, 16'h0004);
    check("sra_shamt", bus.Out_shamt, 4'h4);
    check("sra_ctrl", bus.Out_shift_ctrl, 2'b11);
    check("sra_is_shift", bus.Out_is_shift, 1'b1);
    drive_in(OP_SRL, 4'h3, 4'h2, 16'hF00F, 4'h9, 16'h9999, 4'hF);
    tick();
    idle_in();
    check("srl_ctrl", bus.Out_shift_ctrl, 2'b10);
    check("srl_b", bus.Out_b, 16'h000F);
    check("srl_op", bus.Out_op, OP_SRL);
    drive_in(OP_SLL, 4'h3, 4'h2, 16'h0001, 4'h9, 16'h9999, 4'h1);
    tick();
    idle_in();
    check("sll_ctrl", bus.Out_shift_ctrl, 2'b00);
    check("sll_is_shift", bus.Out_is_shift, 1'b1);
    tick();

    // Capture forwarding: EX beats MEM, MEM alone, R0 never forwarded
    drive_in(4'h1, 4'h8, 4'h5, 16'h5555, 4'h6, 16'h6666, 4'h0);
    set_ex(4'h5, 16'hAAAA);
    set_mem(4'h5, 16'hBBBB);
    tick();
    idle_in();
    check("fwd_ex_prio_a", bus.Out_a, 16'hAAAA);
    check("fwd_nohit_b", bus.Out_b, 16'h6666);
    drive_in(4'h1, 4'h8, 4'h5, 16'h5555, 4'h5, 16'h6666, 4'h0);
    set_mem(4'h5, 16'hBBBB);
    tick();
    idle_in();
    check("fwd_mem_a", bus.Out_a, 16'hBBBB);
    check("fwd_mem_b", bus.Out_b, 16'hBBBB);
    drive_in(4'h1, 4'h8, 4'h0, 16'h0F0F, 4'h0, 16'h0E0E, 4'h0);
    set_ex(4'h0, 16'hCCCC);
    set_mem(4'h0, 16'hDDDD);
    tick();
    idle_in();
    check("fwd_r0_a", bus.Out_a, 16'h0F0F);
    check("fwd_r0_b", bus.Out_b, 16'h0E0E);
    tick();
    check("fwd_drained", bus.Out_valid, 1'b0);

    // Full stage, blocked third input, ordering via expected queue
    bus.Out_ready = 1'b0;
    drive_in(4'h2, 4'h1, 4'h1, 16'h0A01, 4'h0, 16'h0, 4'h0);
    exp_q.push_back(16'h0A01);
    tick();
    check("fill1_count", dbg_count, 2'd1);
    check("fill1_in_ready", bus.In_ready, 1'b1);
    drive_in(4'h2, 4'h2, 4'h1, 16'h0B02, 4'h0, 16'h0, 4'h0);
    exp_q.push_back(16'h0B02);
    tick();
    check("full_in_ready", bus.In_ready, 1'b0);
    check("full_count", dbg_count, 2'd2);
    drive_in(4'h2, 4'h3, 4'h1, 16'h0C03, 4'h0, 16'h0, 4'h0);
    tick();
    check("blocked_count", dbg_count, 2'd2);
    check("blocked_head", bus.Out_a, exp_q[0]);
    bus.Out_ready = 1'b1;
    check("order_pop1", bus.Out_a, exp_q.pop_front());
    tick();
    check("after_pop_count", dbg_count, 2'd1);
    check("after_pop_in_ready", bus.In_ready, 1'b1);
    exp_q.push_back(16'h0C03);
    check("order_pop2", bus.Out_a, exp_q.pop_front());
    tick();
    idle_in();
    check("pushpop_count", dbg_count, 2'd1);
    check("order_pop3", bus.Out_a, exp_q.pop_front());
    tick();
    check("order_drained", bus.Out_valid, 1'b0);
    check("order_queue_empty", exp_q.size(), 0);

    // Snooping while held
    bus.Out_ready = 1'b0;
    drive_in(4'h0, 4'h4, 4'h1, 16'h0001, 4'h7, 16'h0777, 4'h0);
    tick();
    idle_in();
    check("snoop_pre_b", bus.Out_b, 16'h0777);
    set_mem(4'h7, 16'h1234);
    tick();
    idle_in();
    check("snoop_mem_b", bus.Out_b, 16'h1234);
    set_ex(4'h7, 16'h5678);
    set_mem(4'h7, 16'h9999);
    tick();
    idle_in();
    check("snoop_ex_prio_b", bus.Out_b, 16'h5678);
    check("snoop_a_kept", bus.Out_a, 16'h0001);
    tick();
    check("snoop_hold_b", bus.Out_b, 16'h5678);
    bus.Out_ready = 1'b1;
    tick();
    check("snoop_drained", bus.Out_valid, 1'b0);

    // Flush with the stage full, then with In_ready high
    bus.Out_ready = 1'b0;
    drive_in(4'h2, 4'h1, 4'h1, 16'h1001, 4'h0, 16'h0, 4'h0);
    tick();
    drive_in(4'h2, 4'h2, 4'h1, 16'h2002, 4'h0, 16'h0, 4'h0);
    tick();
    check("pre_flush_count", dbg_count, 2'd2);
    drive_in(4'h2, 4'h3, 4'h1, 16'h3003, 4'h0, 16'h0, 4'h0);
    bus.Flush = 1'b1;
    tick();
    idle_in();
    check("flush_valid", bus.Out_valid, 1'b0);
    check("flush_count", dbg_count, 2'd0);
    check("flush_in_ready", bus.In_ready, 1'b1);
    tick();
    check("flush_no_ghost", bus.Out_valid, 1'b0);
    drive_in(4'h2, 4'h1, 4'h1, 16'h1001, 4'h0, 16'h0, 4'h0);
    tick();
    drive_in(4'h2, 4'h3, 4'h1, 16'h3003, 4'h0, 16'h0, 4'h0);
    bus.Flush = 1'b1;
    tick();
    idle_in();
    check("flush2_count", dbg_count, 2'd0);
    check("flush2_valid", bus.Out_valid, 1'b0);
    drive_in(4'h2, 4'h5, 4'h1, 16'h4004, 4'h0, 16'h0, 4'h0);
    tick();
    idle_in();
    check("post_flush_a", bus.Out_a, 16'h4004);
    check("post_flush_count", dbg_count, 2'd1);

    // Asynchronous reset mid-stream
    drive_in(4'h2, 4'h6, 4'h1, 16'h5A5A, 4'h0, 16'h0, 4'h0);
    tick();
    idle_in();
    check("pre_rst_count", dbg_count, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.Out_valid, 1'b0);
    check("mid_rst_a", bus.Out_a, 16'h0);
    check("mid_rst_b", bus.Out_b, 16'h0);
    check("mid_rst_count", dbg_count, 2'd0);
    check("mid_rst_in_ready", bus.In_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", bus.Out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
